// File: rtl/stack_sequencer.sv
// Multi-cycle PUSH/POP sequencer for the writeback stage: reads SP, bounds-checks,
// performs the data-memory access, writes the destination register and updates SP.
module stack_sequencer #(
  parameter logic [4:0]  SP_IDX = 5'd7,
  parameter logic [15:0] SP_LO  = 16'h0100,
  parameter logic [15:0] SP_HI  = 16'h0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_pop,
  input  logic [15:0] req_data,
  input  logic [4:0]  req_dst,
  output logic        reg_r_en,
  output logic [4:0]  reg_r_idx,
  input  logic [15:0] reg_r_data,
  output logic        reg_w_en,
  output logic [4:0]  reg_w_idx,
  output logic [15:0] reg_w_data,
  output logic        mem_r_en,
  output logic [15:0] mem_r_addr,
  input  logic [15:0] mem_r_data,
  output logic        mem_w_en,
  output logic [15:0] mem_w_addr,
  output logic [15:0] mem_w_data,
  output logic        done,
  output logic        fault,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RSP   = 3'd1,
    S_CHK   = 3'd2,
    S_PUSH  = 3'd3,
    S_PRD   = 3'd4,
    S_PWB   = 3'd5,
    S_WSP   = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  state_t      state_r;
  logic [15:0] sp_r;
  logic        is_pop_r;
  logic [15:0] data_r;
  logic [4:0]  dst_r;

  logic        req_ready_r;
  logic        reg_r_en_r;
  logic [4:0]  reg_r_idx_r;
  logic        reg_w_en_r;
  logic [4:0]  reg_w_idx_r;
  logic [15:0] reg_w_data_r;
  logic        pwb_r;
  logic        mem_r_en_r;
  logic [15:0] mem_r_addr_r;
  logic        mem_w_en_r;
  logic [15:0] mem_w_addr_r;
  logic [15:0] mem_w_data_r;
  logic        done_r;
  logic        fault_r;
  logic        busy_r;

  logic        bounds_fault_s;

  // Bounds check evaluated on the SP value arriving in the CHK cycle.
  always_comb begin
    bounds_fault_s = 1'b0;
    if (is_pop_r) begin
      bounds_fault_s = (reg_r_data >= SP_HI);
    end else begin
      bounds_fault_s = (reg_r_data <= SP_LO);
    end
  end

  // Sequencer FSM; every output register is loaded with the value for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      sp_r         <= 16'd0;
      is_pop_r     <= 1'b0;
      data_r       <= 16'd0;
      dst_r        <= 5'd0;
      req_ready_r  <= 1'b0;
      reg_r_en_r   <= 1'b0;
      reg_r_idx_r  <= 5'd0;
      reg_w_en_r   <= 1'b0;
      reg_w_idx_r  <= 5'd0;
      reg_w_data_r <= 16'd0;
      pwb_r        <= 1'b0;
      mem_r_en_r   <= 1'b0;
      mem_r_addr_r <= 16'd0;
      mem_w_en_r   <= 1'b0;
      mem_w_addr_r <= 16'd0;
      mem_w_data_r <= 16'd0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      req_ready_r  <= 1'b0;
      reg_r_en_r   <= 1'b0;
      reg_r_idx_r  <= 5'd0;
      reg_w_en_r   <= 1'b0;
      reg_w_idx_r  <= 5'd0;
      reg_w_data_r <= 16'd0;
      pwb_r        <= 1'b0;
      mem_r_en_r   <= 1'b0;
      mem_r_addr_r <= 16'd0;
      mem_w_en_r   <= 1'b0;
      mem_w_addr_r <= 16'd0;
      mem_w_data_r <= 16'd0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
      busy_r       <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready_r) begin
            is_pop_r    <= req_is_pop;
            data_r      <= req_data;
            dst_r       <= req_dst;
            state_r     <= S_RSP;
            reg_r_en_r  <= 1'b1;
            reg_r_idx_r <= SP_IDX;
          end else begin
            state_r     <= S_IDLE;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        S_RSP: begin
          state_r <= S_CHK;
        end
        S_CHK: begin
          sp_r <= reg_r_data;
          if (bounds_fault_s) begin
            state_r <= S_FAULT;
            fault_r <= 1'b1;
          end else if (is_pop_r) begin
            state_r      <= S_PRD;
            mem_r_en_r   <= 1'b1;
            mem_r_addr_r <= reg_r_data;
          end else begin
            state_r      <= S_PUSH;
            mem_w_en_r   <= 1'b1;
            mem_w_addr_r <= reg_r_data - 16'd1;
            mem_w_data_r <= data_r;
          end
        end
        S_PUSH: begin
          state_r      <= S_WSP;
          reg_w_en_r   <= 1'b1;
          reg_w_idx_r  <= SP_IDX;
          reg_w_data_r <= sp_r - 16'd1;
          done_r       <= 1'b1;
        end
        S_PRD: begin
          // Popped value is only on mem_r_data during PWB, so it is muxed straight through.
          state_r     <= S_PWB;
          reg_w_en_r  <= 1'b1;
          reg_w_idx_r <= dst_r;
          pwb_r       <= 1'b1;
        end
        S_PWB: begin
          state_r      <= S_WSP;
          reg_w_en_r   <= 1'b1;
          reg_w_idx_r  <= SP_IDX;
          reg_w_data_r <= sp_r + 16'd1;
          done_r       <= 1'b1;
        end
        S_WSP, S_FAULT: begin
          state_r     <= S_IDLE;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= S_IDLE;
          req_ready_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign reg_r_en   = reg_r_en_r;
  assign reg_r_idx  = reg_r_idx_r;
  assign reg_w_en   = reg_w_en_r;
  assign reg_w_idx  = reg_w_idx_r;
  assign reg_w_data = pwb_r ? mem_r_data : reg_w_data_r;
  assign mem_r_en   = mem_r_en_r;
  assign mem_r_addr = mem_r_addr_r;
  assign mem_w_en   = mem_w_en_r;
  assign mem_w_addr = mem_w_addr_r;
  assign mem_w_data = mem_w_data_r;
  assign done       = done_r;
  assign fault      = fault_r;
  assign busy       = busy_r;

endmodule
